// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Optional divider datapath is enabled with the MULDIV_DIV_EN macro.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [CNT_W-1:0] LAST_STEP = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // Two's-complement magnitude; unsigned operands pass through untouched.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide over a single 33-bit adder.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
  input  logic               div_i,
`endif
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] add_a;
  logic [WIDTH:0] add_b;
  logic [WIDTH:0] sum;
  logic           sub;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    add_a = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
    add_b = acc_i[0] ? {1'b0, opnd_i} : '0;
    sub   = 1'b0;
`ifdef MULDIV_DIV_EN
    // Divide: trial value is {R, Q msb}, i.e. the remainder after the left shift.
    if (div_i) begin
      add_a = acc_i[2*WIDTH-1:WIDTH-1];
      add_b = {1'b0, opnd_i};
      sub   = 1'b1;
    end
`endif
    sum   = add_a + (add_b ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};
    acc_o = {sum, acc_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    if (div_i) begin
      acc_o = sum[WIDTH] ? {add_a[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0}
                         : {sum[WIDTH-1:0],   acc_i[WIDTH-2:0], 1'b1};
    end
`endif
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO: sign fix-up, 32-step FSM, MTHI/MTLO.
// Without MULDIV_DIV_EN, DIV/DIVU complete in one edge and leave HI/LO unchanged.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
`ifdef MULDIV_DIV_EN
  logic               div_q, div_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
`endif

  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] result;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign mag_a     = magnitude(a, op_signed);
  assign mag_b     = magnitude(b, op_signed);

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .div_i  (div_q),
`endif
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // Post-fix is applied to the final step's output so HI/LO land on the CALC->DONE edge.
  always_comb begin
    result = neg_q ? (~step_acc + 1'b1) : step_acc;
`ifdef MULDIV_DIV_EN
    if (div_q) begin
      if (opnd_q == '0) begin
        result = {a_raw_q, {WIDTH{1'b1}}};
      end else begin
        result[WIDTH-1:0]       = neg_q ? (~step_acc[WIDTH-1:0] + 1'b1)
                                        : step_acc[WIDTH-1:0];
        result[2*WIDTH-1:WIDTH] = rem_neg_q ? (~step_acc[2*WIDTH-1:WIDTH] + 1'b1)
                                            : step_acc[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    hi_d    = wr_hi ? wr_data : hi_q;
    lo_d    = wr_lo ? wr_data : lo_q;
`ifdef MULDIV_DIV_EN
    div_d     = div_q;
    rem_neg_d = rem_neg_q;
    a_raw_d   = a_raw_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_d   = CALC;
          div_d     = op_div;
          rem_neg_d = op_signed && a[WIDTH-1];
          a_raw_d   = a;
`else
          state_d   = op_div ? DONE : CALC;
`endif
          cnt_d  = '0;
          neg_d  = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          opnd_d = mag_a;
          acc_d  = {{WIDTH{1'b0}}, mag_b};
`ifdef MULDIV_DIV_EN
          if (op_div) begin
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
          end
`endif
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          cnt_d   = '0;
          hi_d    = result[2*WIDTH-1:WIDTH];
          lo_d    = result[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIV_EN
      div_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      a_raw_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
      div_q     <= div_d;
      rem_neg_q <= rem_neg_d;
      a_raw_q   <= a_raw_d;
`endif
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer for the MIPS pipeline's EX stage, owning the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU requests from the decoder and runs a 32-step shift-add multiply or restoring divide over one shared adder/subtractor. While it runs it holds `busy` so the hazard unit stalls MFHI/MFLO and further mul/div issue. It completes MTHI/MTLO writes directly.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request strobe; sampled only in IDLE or DONE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a`  in  WIDTH  multiplicand / dividend (rs)
- `b`  in  WIDTH  multiplier / divisor (rt)
- `flush`  in  1  abort the in-flight operation (branch/exception squash)
- `wr_hi`, `wr_lo`  in  1 each  MTHI/MTLO write enables
- `wr_data`  in  WIDTH  MTHI/MTLO data
- `busy`  out  1  high while in CALC
- `done`  out  1  one-cycle completion pulse
- `hi`, `lo`  out  WIDTH  architectural HI/LO

## Operation
- States: IDLE, CALC, DONE.
  - IDLE or DONE, with `start`: go to CALC. Operands are latched, `cnt`=0.
  - CALC: `cnt` increments each cycle. When `cnt`==31, go to DONE.
  - DONE: go to IDLE, or to CALC if `start` is high.
- Signed ops (MULT, DIV): latch |a| and |b| and record the signs. Unsigned ops take operands raw.
- Multiply: 64-bit accumulator {P_hi, P_lo}, P_lo=|b| initially. Each step adds |a| to P_hi if P_lo[0]=1, then shifts right one bit, keeping a 33-bit carry. Final result is negated if the signs differ. HI=result[63:32], LO=result[31:0].
- Divide: restoring division. Each step shifts {R,Q} left one bit, trial-subtracts |b|, and restores if the result is negative.
  - Quotient goes to LO, remainder to HI.
  - Signed divide: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Divide by zero: LO=0xFFFFFFFF, HI=a (raw), regardless of sign. No trap.
- HI/LO update only on the edge leaving CALC, i.e. the CALC→DONE edge.
- `wr_hi`/`wr_lo` update HI/LO at the next edge in any state.
  - If a write coincides with the CALC→DONE edge, the computed result wins.
- `start` during CALC is ignored. The requester must not retry without `busy` low.
- `flush` during CALC: go to IDLE at the next edge. HI/LO are unchanged and `done` does not pulse. `flush` overrides a coincident completion. `flush` in IDLE/DONE has no effect, and `start` wins over it.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `cnt`=0, operand latches 0.
- Reset mid-operation abandons the operation immediately and returns all of the above to reset values.
- `start` in cycle 0 gives:
  - `busy`=1 in cycles 1–32 (32 steps).
  - New HI/LO and `done`=1 in cycle 33. Total latency is 33 cycles from the `start` cycle.
- Back-to-back: `start` in cycle 33 is accepted, with no bubble.
- `busy` and `done` are registered (state decode only) and never combinational from inputs.

## Configuration
- `MULDIV_DIV_EN` defined: full behaviour as above.
- Undefined: divider datapath and restore logic are omitted.
  - DIV/DIVU are still accepted. They go IDLE→DONE in one edge (`done` in cycle 1, `busy` never high) with HI/LO unchanged.
  - MULT/MULTU are unaffected.

## Structure
- Shared package `muldiv_pkg`:
  - `WIDTH`
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`
  - state enum `muldiv_state_t` {IDLE, CALC, DONE}
- One sub-module, `muldiv_step`: purely combinational single-iteration datapath. It takes the current accumulator, the latched |b| or |a|, and mode, and returns the next accumulator. Its 33-bit add/sub is the only adder in the block.
- Sign pre-fix, post-fix and the FSM stay in `muldiv_ctrl`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, `start` cycle 0 → `busy` cycles 1–32; cycle 33: `done`=1, HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (−3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Back-to-back DIV started in cycle 33 → `done` in cycle 66.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=0 → LO=0xFFFFFFFF, HI=100.
- HI=0x11 preset via MTHI; MULTU 3×4 started, `flush` in cycle 10 → `busy`=0 in cycle 11, no `done`, HI=0x11. `start` pulsed in cycle 5 of a run is ignored.
- `wr_lo`=1, `wr_data`=0xAAAA in cycle 32 of MULTU 2×3 → LO=6 in cycle 33. `wr_hi` in cycle 20 → HI shows the value until cycle 33, then 0.
- `reset` asserted asynchronously mid-CALC → outputs return to 0 before the next edge. Build without `MULDIV_DIV_EN`: DIVU 9/3 → `done` cycle 1, HI/LO unchanged.
